// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - 16x oversampled UART receiver: start/data/parity/stop decode with per-frame error flags
module uart_rx_engine #(
    parameter int N_BIT      = 8,
    parameter int DVSR       = 326,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [N_BIT-1:0] rx_data_out,
    output logic             rx_valid,
    output logic             parity_error,
    output logic             frame_error,
    output logic             busy
);

    localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = $clog2(N_BIT) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BREAK} state_t;

    state_t           state, state_n;
    logic             rx_meta, rx_s;
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [3:0]       s_cnt, s_cnt_n;
    logic [NW-1:0]    n_cnt, n_cnt_n;
    logic [N_BIT-1:0] shift_reg, shift_n;
    logic             par_err, par_err_n;
    logic             fr_err, fr_err_n;
    logic             deliver;

    assign tick = (tick_cnt == TW'(DVSR - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            tick_cnt     <= '0;
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            shift_reg    <= '0;
            par_err      <= 1'b0;
            fr_err       <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data_out  <= '0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
            state     <= state_n;
            s_cnt     <= s_cnt_n;
            n_cnt     <= n_cnt_n;
            shift_reg <= shift_n;
            par_err   <= par_err_n;
            fr_err    <= fr_err_n;
            rx_valid  <= deliver;
            // Results are captured on the mid-stop tick so they are stable while state is DONE.
            if (deliver) begin
                rx_data_out  <= shift_reg;
                parity_error <= (PARITY_EN != 0) ? par_err : 1'b0;
                frame_error  <= fr_err_n;
            end
        end
    end

    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        n_cnt_n   = n_cnt;
        shift_n   = shift_reg;
        par_err_n = par_err;
        fr_err_n  = fr_err;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == 4'd7) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        shift_n = {rx_s, shift_reg[N_BIT-1:1]};
                        s_cnt_n = '0;
                        if (n_cnt == NW'(N_BIT - 1)) begin
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_cnt_n = n_cnt + NW'(1);
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        par_err_n = rx_s ^ (^shift_reg) ^ (PARITY_ODD != 0);
                        state_n   = STOP;
                        s_cnt_n   = '0;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt == 4'd15) begin
                        fr_err_n = ~rx_s;
                        state_n  = DONE;
                        s_cnt_n  = '0;
                        deliver  = 1'b1;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
            end
            DONE: begin
                state_n = fr_err ? BREAK : IDLE;
            end
            BREAK: begin
                // A line held low after a framing error must go high before a new start is seen.
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - directed and randomized frame bench for uart_rx_engine with a frame-level scoreboard
module tb_uart_rx_engine;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];

    uart_rx_engine #(
        .N_BIT(8),
        .DVSR(4),
        .PARITY_EN(1),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data_out(rx_data_out),
        .rx_valid(rx_valid),
        .parity_error(parity_error),
        .frame_error(frame_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Expected frame content is derived from what is put on the wire, not from the receiver.
    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop_v);
        exp_t e;
        logic par_bit;
        e.d = d;
        e.pe = par_bad;
        e.fe = ~stop_v;
        exp_q.push_back(e);
        par_bit = logic'($countones(d) % 2) ^ par_bad;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
        hold(par_bit, BIT);
        hold(stop_v, BIT);
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            exp_t e;
            strobes++;
            check("strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rx_data_out", rx_data_out, e.d);
                check("parity_error", parity_error, e.pe);
                check("frame_error", frame_error, e.fe);
            end
        end
    end

    initial begin
        int s0;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_data", rx_data_out, 0);
        check("reset_parity_error", parity_error, 0);
        check("reset_frame_error", frame_error, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        hold(1'b1, BIT);

        // 1: clean 0xA5
        s0 = strobes;
        send_frame(8'hA5, 1'b0, 1'b1);
        hold(1'b1, BIT);
        check("t1_strobes", strobes - s0, 1);

        // 2: 0x3C with wrong parity
        s0 = strobes;
        send_frame(8'h3C, 1'b1, 1'b1);
        hold(1'b1, BIT);
        check("t2_strobes", strobes - s0, 1);

        // 3: 0x81 with stop bit 0, then line held low
        s0 = strobes;
        send_frame(8'h81, 1'b0, 1'b0);
        hold(1'b0, 20 * BIT);
        check("t3_busy_while_low", busy, 1);
        check("t3_strobes", strobes - s0, 1);
        rx = 1'b1;
        for (int i = 0; i < 10 && busy; i++) @(negedge clk);
        check("t3_busy_release", busy, 0);

        // 4: short low glitch from idle
        hold(1'b1, BIT);
        s0 = strobes;
        hold(1'b0, 16);
        rx = 1'b1;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("t4_busy_after_glitch", busy, 0);
        hold(1'b1, BIT);
        check("t4_strobes", strobes - s0, 0);

        // 5: reset during data bit 3 of 0xFF, then 0x5A
        s0 = strobes;
        hold(1'b0, BIT);
        for (int i = 0; i < 3; i++) hold(1'b1, BIT);
        hold(1'b1, 20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rx_valid", rx_valid, 0);
        check("t5_data", rx_data_out, 0);
        check("t5_parity_error", parity_error, 0);
        check("t5_frame_error", frame_error, 0);
        check("t5_busy", busy, 0);
        hold(1'b1, 3 * BIT);
        check("t5_no_strobe", strobes - s0, 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        hold(1'b1, BIT);
        check("t5_strobes", strobes - s0, 1);

        // 6: back-to-back frames with no idle gap
        s0 = strobes;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        hold(1'b1, BIT);
        check("t6_strobes", strobes - s0, 2);

        // randomized frames with random parity corruption and random gaps
        s0 = strobes;
        for (int k = 0; k < 10; k++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, 1'b1);
            hold(1'b1, 17 * $urandom_range(0, 3));
        end
        hold(1'b1, BIT);
        check("rand_strobes", strobes - s0, 10);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
